load_store_unit: RTL
====================

# load_store_unit

Request/response front-end for the data `Memory`. Sits between the core's execute stage and `Memory`. Accepts one load or store per handshake and checks alignment, func3 legality and address range. Drives `Memory`'s synchronous port, captures its one-cycle-latency read data, and returns a held response with a RISC-V fault cause.

## Interface
Parameters:
- `MEM_SIZE`, default 4096: byte size of the attached `Memory`; addresses `>= MEM_SIZE` are access faults.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: core request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_func3` in 3: RISC-V load/store func3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, unshifted.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: core accepts the response.
- `resp_rdata` out 32: load result from `Memory`; 0 for stores and faults.
- `resp_fault` out 1: request was not performed.
- `resp_cause` out 4: 2 illegal, 4 load misaligned, 5 load access fault, 6 store misaligned, 7 store access fault; 0 when no fault.
- `mem_address` out 32, `mem_func3` out 3, `mem_write_en` out 1, `mem_data_in` out 32: drive `Memory`.
- `mem_data_out` in 32: `Memory` registered read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- `req_ready` = (state == IDLE).
- Accept on `req_valid && req_ready`. Register addr, func3, write and wdata.
- Legality checks, priority order:
  - Illegal: loads with func3 ∈ {3, 6, 7}; stores with func3 ∉ {0, 1, 2}. Cause 2.
  - Misaligned: func3 1/5 with `addr[0]`; func3 2 with `addr[1:0] != 0`. Cause 4 for loads, 6 for stores.
  - Out of range: `addr >= MEM_SIZE`. Cause 5 for loads, 7 for stores.
- Faulting request: IDLE → RESP directly with `resp_fault=1` and cause set. No memory cycle; `mem_write_en` stays 0.
- Legal request: IDLE → ACCESS → WAIT → RESP.
  - ACCESS: `mem_address`, `mem_func3` and `mem_data_in` (= `req_wdata`, unmodified) driven from registers. `mem_write_en` = `req_write` for exactly this one cycle.
  - WAIT: `mem_write_en=0`, mem address/func3 held. `mem_data_out` is registered into `resp_rdata` at the end of WAIT for loads; `resp_rdata` is 0 for stores.
  - RESP: `resp_valid=1`. `resp_rdata`, `resp_fault` and `resp_cause` are held stable until `resp_ready`.
- RESP with `resp_ready`: → IDLE, `resp_valid` falls next cycle.
- A request arriving in the same cycle as the `resp_ready` handshake is not accepted; `req_ready` is 0 in RESP. It is accepted in the following IDLE cycle.
- Sign and zero extension are performed by `Memory`. This unit passes `mem_data_out` through unchanged.

## Timing
- Reset values:
  - state IDLE; `req_ready` 1.
  - `resp_valid` 0, `resp_fault` 0, `resp_cause` 0, `resp_rdata` 0.
  - `mem_write_en` 0, `mem_address` 0, `mem_func3` 2, `mem_data_in` 0.
- Accept at edge E0:
  - ACCESS in cycle E0–E1; `Memory` samples at E1.
  - WAIT in E1–E2; `rdata` captured at E2.
  - `resp_valid` high from E2.
- Legal latency: 3 cycles from accept to `resp_valid`.
- Fault latency: 1 cycle from accept to `resp_valid`.
- Minimum legal throughput: 1 request per 4 cycles.
- `mem_write_en` is a registered output that is never high outside ACCESS. Asserting `reset` forces it to 0 asynchronously.
- Reset mid-operation (any state):
  - The transaction is dropped and no response is produced.
  - A store in ACCESS that has not reached its sampling edge is not written.
  - All outputs return to their reset values immediately.

## Structure
- Package `lsu_pkg`:
  - state enum.
  - func3 constants: LB 0, LH 1, LW 2, LBU 4, LHU 5, SB 0, SH 1, SW 2.
  - cause constants: 2, 4, 5, 6, 7.
- Sub-module `lsu_check`: combinational legality checker. Inputs: write, func3, addr, `MEM_SIZE`. Outputs: fault, cause.
- Top level holds the FSM and the registers only.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store response has rdata 0 and fault 0. `mem_write_en` is high exactly one cycle. Load `resp_valid` rises 3 cycles after accept with rdata 0xDEADBEEF.
- After SW 0x10 = 0x80818283: LBU 0x11 → 0x00000082; LHU 0x12 → 0x00008081.
- LH 0x13 → `resp_valid` 1 cycle after accept, fault 1, cause 4, no `mem_write_en` pulse. SW 0x22 → cause 6. LW `MEM_SIZE` → cause 5. Load func3 7 → cause 2.
- Hold `resp_ready` low 5 cycles in RESP → rdata, fault and cause stable. `req_ready` 0 throughout. The next request is accepted the cycle after the handshake.
- Assert `reset` during ACCESS of SW 0x30 = 0x12345678 → `mem_write_en` 0 immediately, all outputs at reset values, no response. A later LW 0x30 returns the prior contents.
- Back-to-back accepted requests at maximum rate → exactly one response per request, in order, with no lost or duplicated `resp_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : shared state encoding, func3 and fault-cause constants for the LSU
// Revision: 1.0
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [3:0] CAUSE_NONE         = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN  = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS    = 4'd7;

endpackage
`default_nettype wire

// File: rtl/lsu_check.sv
`default_nettype none
// ============================================================================
// lsu_check : combinational legality check (illegal > misaligned > range)
// Revision: 1.0
// ============================================================================
module lsu_check
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 4096
) (
  input  logic        write_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  output logic        fault_o,
  output logic [3:0]  cause_o
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  logic illegal;
  logic misaligned;
  logic out_of_range;

  always_comb begin
    if (write_i) begin
      illegal = !(func3_i inside {F3_SB, F3_SH, F3_SW});
    end else begin
      illegal = !(func3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    misaligned   = ((func3_i == F3_LH || func3_i == F3_LHU) && addr_i[0]) ||
                   ((func3_i == F3_LW) && (addr_i[1:0] != 2'b00));
    out_of_range = (addr_i >= MEM_LIMIT);

    fault_o = 1'b1;
    if (illegal) begin
      cause_o = CAUSE_ILLEGAL;
    end else if (misaligned) begin
      cause_o = write_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    end else if (out_of_range) begin
      cause_o = write_i ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
    end else begin
      cause_o = CAUSE_NONE;
      fault_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : request/response front-end driving a synchronous Memory
// Revision: 1.0
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [3:0]  resp_cause,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_func3,
  output logic        mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  func3_q, func3_d;
  logic        write_q, write_d;
  logic        fault_q, fault_d;
  logic [3:0]  cause_q, cause_d;
  logic        we_q, we_d;

  logic        chk_fault;
  logic [3:0]  chk_cause;

  lsu_check #(.MEM_SIZE(MEM_SIZE)) u_check (
    .write_i (req_write),
    .func3_i (req_func3),
    .addr_i  (req_addr),
    .fault_o (chk_fault),
    .cause_o (chk_cause)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    func3_d = func3_q;
    write_d = write_q;
    fault_d = fault_q;
    cause_d = cause_q;
    we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          func3_d = req_func3;
          write_d = req_write;
          wdata_d = req_wdata;
          rdata_d = '0;
          fault_d = chk_fault;
          cause_d = chk_cause;
          if (chk_fault) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
            we_d    = req_write;
          end
        end
      end
      ST_ACCESS: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_RESP;
        // Memory's registered read data is valid for the whole WAIT cycle.
        if (!write_q) rdata_d = mem_data_out;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      func3_q <= F3_LW;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      func3_q <= func3_d;
      write_q <= write_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      we_q    <= we_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign resp_rdata   = rdata_q;
  assign resp_fault   = fault_q;
  assign resp_cause   = cause_q;
  assign mem_address  = addr_q;
  assign mem_func3    = func3_q;
  assign mem_write_en = we_q;
  assign mem_data_in  = wdata_q;

endmodule
`default_nettype wire
